// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares one SPI master register port among NUM_REQ
// requesters, running select/enable/poll/write/poll/read/disable per byte.
module spi_xfer_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter logic [7:0]  CTRL_VAL     = 8'h8B,
    parameter int          POLL_TIMEOUT = 1023
) (
    input  logic                 I_CLK,
    input  logic                 I_RESETN,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] tx_data,
    output logic [7:0]           rx_data,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 I_TX_EN,
    output logic [2:0]           I_WADDR,
    output logic [7:0]           I_WDATA,
    output logic                 I_RX_EN,
    output logic [2:0]           I_RADDR,
    input  logic [7:0]           O_RDATA
);
    localparam int CW = (POLL_TIMEOUT < 1) ? 1 : $clog2(POLL_TIMEOUT + 1);
    localparam logic [2:0] A_RXD = 3'd0, A_TXD = 3'd1, A_STAT = 3'd2,
                           A_CTRL = 3'd3, A_SS = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_SS, S_WR_CTRL, S_POLL_TX, S_WR_TX,
        S_POLL_RX, S_RD_RX, S_WR_OFF, S_DONE
    } state_t;

    state_t          r_state;
    logic [1:0]      r_step;
    logic [2:0]      r_ptr;
    logic [CW-1:0]   r_cnt;
    logic            r_abort;
    logic [7:0]      r_txb;
    logic [7:0]      r_rdata;

    logic            w_found;
    logic [2:0]      w_gnt;
    logic [7:0]      w_txb;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_poll_ok;

    // Pick the set request with the smallest distance after the pointer.
    always_comb begin
        int best;
        int d;
        w_found = 1'b0;
        w_gnt   = '0;
        w_txb   = '0;
        best    = NUM_REQ + 1;
        d       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i > int'(r_ptr)) ? i - int'(r_ptr) : i + NUM_REQ - int'(r_ptr);
            if (req[i] && d < best) begin
                best    = d;
                w_found = 1'b1;
                w_gnt   = 3'(i);
                w_txb   = tx_data[i*8 +: 8];
            end
        end
    end

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_poll_ok = (r_state == S_POLL_TX) ? (r_rdata[5] & r_rdata[4]) : r_rdata[6];

    // Reads: strobe, wait, capture O_RDATA on step 2, act on step 3.
    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_ptr    <= 3'(NUM_REQ - 1);
            r_cnt    <= '0;
            r_abort  <= 1'b0;
            r_txb    <= '0;
            r_rdata  <= '0;
            rx_data  <= '0;
            done     <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
            I_TX_EN  <= 1'b0;
            I_WADDR  <= '0;
            I_WDATA  <= '0;
            I_RX_EN  <= 1'b0;
            I_RADDR  <= '0;
        end else begin
            I_TX_EN <= 1'b0;
            I_RX_EN <= 1'b0;
            done    <= '0;
            err     <= 1'b0;
            r_step  <= r_step + 2'd1;
            if (r_step == 2'd2) r_rdata <= O_RDATA;
            case (r_state)
                S_IDLE: begin
                    r_step <= '0;
                    if (w_found) begin
                        r_state  <= S_WR_SS;
                        r_ptr    <= w_gnt;
                        grant_id <= w_gnt;
                        r_txb    <= w_txb;
                        busy     <= 1'b1;
                        I_TX_EN  <= 1'b1;
                        I_WADDR  <= A_SS;
                        I_WDATA  <= 8'd1 << w_gnt;
                    end
                end
                S_WR_SS: if (r_step[0]) begin
                    r_step  <= '0;
                    r_state <= S_WR_CTRL;
                    I_TX_EN <= 1'b1;
                    I_WADDR <= A_CTRL;
                    I_WDATA <= CTRL_VAL;
                end
                S_WR_CTRL, S_WR_TX: if (r_step[0]) begin
                    r_step  <= '0;
                    r_state <= (r_state == S_WR_CTRL) ? S_POLL_TX : S_POLL_RX;
                    I_RX_EN <= 1'b1;
                    I_RADDR <= A_STAT;
                end
                S_POLL_TX, S_POLL_RX: if (r_step == 2'd3) begin
                    if (w_poll_ok) begin
                        r_cnt <= '0;
                        if (r_state == S_POLL_TX) begin
                            r_state <= S_WR_TX;
                            I_TX_EN <= 1'b1;
                            I_WADDR <= A_TXD;
                            I_WDATA <= r_txb;
                        end else begin
                            r_state <= S_RD_RX;
                            I_RX_EN <= 1'b1;
                            I_RADDR <= A_RXD;
                        end
                    end else if (w_cnt_inc == CW'(POLL_TIMEOUT)) begin
                        r_abort <= 1'b1;
                        r_state <= S_WR_OFF;
                        I_TX_EN <= 1'b1;
                        I_WADDR <= A_CTRL;
                        I_WDATA <= 8'h00;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                        I_RX_EN <= 1'b1;
                    end
                end
                S_RD_RX: if (r_step == 2'd3) begin
                    rx_data <= r_rdata;
                    r_state <= S_WR_OFF;
                    I_TX_EN <= 1'b1;
                    I_WADDR <= A_CTRL;
                    I_WDATA <= 8'h00;
                end
                S_WR_OFF: if (r_step[0]) begin
                    r_step  <= '0;
                    r_state <= S_DONE;
                    done    <= NUM_REQ'(1) << grant_id;
                    err     <= r_abort;
                    if (r_abort) rx_data <= 8'h00;
                end
                S_DONE: begin
                    r_step  <= '0;
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    r_abort <= 1'b0;
                    r_cnt   <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench: a small SPI-master register model answers reads, and each
// transfer's writes, done pulse and latency are checked against hand values.
module tb_spi_xfer_arbiter;
    logic        I_CLK = 1'b0;
    logic        I_RESETN = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] tx_data = '0;
    logic [7:0]  O_RDATA = '0;
    logic        sel = 1'b0;
    logic [3:0]  req_a, req_b;

    logic [7:0] a_rx, b_rx;
    logic [3:0] a_done, b_done;
    logic       a_err, b_err, a_busy, b_busy, a_txen, b_txen, a_rxen, b_rxen;
    logic [2:0] a_gid, b_gid, a_waddr, b_waddr, a_raddr, b_raddr;
    logic [7:0] a_wdata, b_wdata;
    logic [32:0] a_all, b_all, m_all;
    logic [7:0] m_rx, m_wdata;
    logic [3:0] m_done;
    logic       m_err, m_busy, m_txen, m_rxen;
    logic [2:0] m_gid, m_waddr, m_raddr;

    int vectors = 0, miscompares = 0;
    int cyc = 0, nwr = 0, ss_cyc = 0, d_cyc = 0, prev_d = 0;
    logic [2:0] wr_addr [16];
    logic [7:0] wr_data [16];
    logic [7:0] st_q [$];
    logic [7:0] st_dflt = 8'h70, rx_byte = 8'h00;
    logic       done_seen = 1'b0, both_hi = 1'b0, d_err = 1'b0;
    logic [3:0] d_vec = '0;
    logic [7:0] d_rx = '0;
    logic [3:0] exp_done [4];
    logic [7:0] exp_ss [4];
    logic [7:0] exp_tx [4];

    assign req_a = sel ? 4'b0 : req;
    assign req_b = sel ? req : 4'b0;

    spi_xfer_arbiter u_dut (
        .I_CLK(I_CLK), .I_RESETN(I_RESETN), .req(req_a), .tx_data(tx_data),
        .rx_data(a_rx), .done(a_done), .err(a_err), .busy(a_busy), .grant_id(a_gid),
        .I_TX_EN(a_txen), .I_WADDR(a_waddr), .I_WDATA(a_wdata),
        .I_RX_EN(a_rxen), .I_RADDR(a_raddr), .O_RDATA(O_RDATA));

    spi_xfer_arbiter #(.POLL_TIMEOUT(3)) u_dut_to (
        .I_CLK(I_CLK), .I_RESETN(I_RESETN), .req(req_b), .tx_data(tx_data),
        .rx_data(b_rx), .done(b_done), .err(b_err), .busy(b_busy), .grant_id(b_gid),
        .I_TX_EN(b_txen), .I_WADDR(b_waddr), .I_WDATA(b_wdata),
        .I_RX_EN(b_rxen), .I_RADDR(b_raddr), .O_RDATA(O_RDATA));

    assign a_all = {a_rx, a_done, a_err, a_busy, a_gid, a_txen, a_waddr, a_wdata, a_rxen, a_raddr};
    assign b_all = {b_rx, b_done, b_err, b_busy, b_gid, b_txen, b_waddr, b_wdata, b_rxen, b_raddr};
    assign m_all = sel ? b_all : a_all;
    assign {m_rx, m_done, m_err, m_busy, m_gid, m_txen, m_waddr, m_wdata, m_rxen, m_raddr} = m_all;

    always #5 I_CLK = ~I_CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: sample on the falling edge, log writes/done, answer reads.
    task automatic tick();
        @(negedge I_CLK);
        cyc++;
        if (m_txen) begin
            if (nwr < 16) begin
                wr_addr[nwr] = m_waddr;
                wr_data[nwr] = m_wdata;
            end
            nwr++;
            if (m_waddr == 3'd4) ss_cyc = cyc;
        end
        if (m_rxen) begin
            if (m_raddr == 3'd2) begin
                if (st_q.size() > 0) O_RDATA = st_q.pop_front();
                else O_RDATA = st_dflt;
            end else begin
                O_RDATA = rx_byte;
            end
        end
        if (m_txen && m_rxen) both_hi = 1'b1;
        if (|m_done) begin
            done_seen = 1'b1;
            d_vec = m_done;
            d_err = m_err;
            d_rx  = m_rx;
            d_cyc = cyc;
        end
    endtask

    task automatic run_xfer(input string tag);
        done_seen = 1'b0;
        for (int i = 0; i < 300 && !done_seen; i++) tick();
        check({tag, " done seen"}, 64'(done_seen), 64'd1);
    endtask

    task automatic do_reset();
        I_RESETN = 1'b0;
        tick();
        I_RESETN = 1'b1;
        tick();
    endtask

    initial begin
        exp_done = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        exp_ss   = '{8'h01, 8'h02, 8'h08, 8'h01};
        exp_tx   = '{8'h11, 8'h22, 8'h44, 8'h11};

        tick(); tick();
        check("reset outputs", 64'(m_all), 64'd0);
        I_RESETN = 1'b1;
        tick();

        // Single transfer from requester 0
        tx_data = 32'h0000_00A5; rx_byte = 8'h3C; nwr = 0; req = 4'b0001;
        run_xfer("single");
        req = 4'b0000;
        check("single nwr", 64'(nwr), 64'd4);
        check("single wr0", 64'({wr_addr[0], wr_data[0]}), 64'({3'd4, 8'h01}));
        check("single wr1", 64'({wr_addr[1], wr_data[1]}), 64'({3'd3, 8'h8B}));
        check("single wr2", 64'({wr_addr[2], wr_data[2]}), 64'({3'd1, 8'hA5}));
        check("single wr3", 64'({wr_addr[3], wr_data[3]}), 64'({3'd3, 8'h00}));
        check("single done", 64'(d_vec), 64'b0001);
        check("single latency", 64'(d_cyc - ss_cyc), 64'd20);
        check("single rx", 64'(d_rx), 64'h3C);
        check("single err", 64'(d_err), 64'd0);
        tick(); tick();
        check("single busy drop", 64'(m_busy), 64'd0);
        check("single rx held", 64'(m_rx), 64'h3C);

        // Round robin with 1011 held
        do_reset();
        tx_data = 32'h4433_2211; rx_byte = 8'h00; req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            nwr = 0;
            run_xfer($sformatf("rr%0d", k));
            check($sformatf("rr%0d done", k), 64'(d_vec), 64'(exp_done[k]));
            check($sformatf("rr%0d ssmask", k), 64'({wr_addr[0], wr_data[0]}), 64'({3'd4, exp_ss[k]}));
            check($sformatf("rr%0d txdata", k), 64'({wr_addr[2], wr_data[2]}), 64'({3'd1, exp_tx[k]}));
            if (k > 0) check($sformatf("rr%0d turnaround", k), 64'(ss_cyc - prev_d), 64'd2);
            prev_d = d_cyc;
        end
        req = 4'b0000;
        tick(); tick();

        // Slow TX ready: three failed TX polls
        st_q = '{8'h00, 8'h00, 8'h00, 8'h30, 8'h40};
        rx_byte = 8'h5A; nwr = 0; req = 4'b0001;
        run_xfer("slow");
        req = 4'b0000;
        check("slow done", 64'(d_vec), 64'b0001);
        check("slow latency", 64'(d_cyc - ss_cyc), 64'd32);
        check("slow err", 64'(d_err), 64'd0);
        check("slow rx", 64'(d_rx), 64'h5A);
        check("slow status reads", 64'(st_q.size()), 64'd0);
        tick(); tick();

        // Requester 2 withdraws after grant; then 3 is favoured over 0
        nwr = 0; req = 4'b0100;
        for (int i = 0; i < 10 && !m_busy; i++) tick();
        check("wd busy", 64'(m_busy), 64'd1);
        tick(); tick();
        req = 4'b0000;
        run_xfer("wd");
        check("wd done", 64'(d_vec), 64'b0100);
        check("wd ssmask", 64'({wr_addr[0], wr_data[0]}), 64'({3'd4, 8'h04}));
        tick(); tick();
        nwr = 0; req = 4'b1001;
        run_xfer("wd next");
        req = 4'b0000;
        check("wd next done", 64'(d_vec), 64'b1000);
        check("wd next ssmask", 64'({wr_addr[0], wr_data[0]}), 64'({3'd4, 8'h08}));
        tick(); tick();

        // Reset during POLL_RX
        nwr = 0; req = 4'b0001;
        for (int i = 0; i < 50 && !(m_txen && m_waddr == 3'd1); i++) tick();
        tick(); tick();
        check("mid in poll_rx", 64'({m_rxen, m_raddr}), 64'({1'b1, 3'd2}));
        req = 4'b1011;
        #2 I_RESETN = 1'b0;
        #1 check("mid async reset", 64'(m_all), 64'd0);
        done_seen = 1'b0;
        tick(); tick();
        check("mid no done", 64'(done_seen), 64'd0);
        I_RESETN = 1'b1;
        nwr = 0;
        run_xfer("mid after");
        req = 4'b0000;
        check("mid first grant", 64'(d_vec), 64'b0001);
        tick(); tick();

        // Timeout on the POLL_TIMEOUT=3 instance
        sel = 1'b1;
        do_reset();
        st_dflt = 8'h70; rx_byte = 8'hC3; nwr = 0; req = 4'b0001;
        run_xfer("to pre");
        req = 4'b0000;
        check("to pre rx", 64'({d_err, d_rx}), 64'({1'b0, 8'hC3}));
        tick(); tick();
        st_dflt = 8'h30; nwr = 0; req = 4'b0001;
        run_xfer("to");
        req = 4'b0000;
        check("to err", 64'(d_err), 64'd1);
        check("to rx", 64'(d_rx), 64'h00);
        check("to latency", 64'(d_cyc - ss_cyc), 64'd24);
        check("to nwr", 64'(nwr), 64'd4);
        check("to ctrl off", 64'({wr_addr[3], wr_data[3]}), 64'({3'd3, 8'h00}));
        tick(); tick();
        st_dflt = 8'h70; rx_byte = 8'h96; nwr = 0; req = 4'b0001;
        run_xfer("to post");
        req = 4'b0000;
        check("to post", 64'({d_vec, d_err, d_rx}), 64'({4'b0001, 1'b0, 8'h96}));
        tick(); tick();

        check("strobes exclusive", 64'(both_hi), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one SPI master IP register interface among NUM_REQ requesters.
- Each requester asks for a single-byte full-duplex transfer to its own slave.
- The block runs the complete register sequence for each transfer: slave select, enable, TX-ready poll, TX write, RX-ready poll, RX read, disable.
- It returns the received byte with a done pulse and reports status-poll timeouts as errors.

Parameters:
- NUM_REQ, 4: number of requesters, 1..8; requester i drives SSMASK = 1<<i.
- CTRL_VAL, 8'h8B: value written to CONTROL to enable a transfer.
- POLL_TIMEOUT, 1023: failed status evaluations allowed per poll phase before abort; counter width is clog2(POLL_TIMEOUT+1).

Ports:
- I_CLK  in  1  system clock; all logic on the rising edge.
- I_RESETN  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester level request; held until that requester's done pulse.
- tx_data  in  NUM_REQ*8  byte i at [8i+7:8i]; sampled at grant.
- rx_data  out  8  received byte; valid while done is high, held afterwards.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  high with done when the transfer aborted on timeout.
- busy  out  1  high from grant until the done cycle inclusive.
- grant_id  out  3  index of the current or last granted requester.
- I_TX_EN  out  1  register write strobe to the SPI master.
- I_WADDR  out  3  write address: 1=TXDATA, 3=CONTROL, 4=SSMASK.
- I_WDATA  out  8  write data.
- I_RX_EN  out  1  register read strobe.
- I_RADDR  out  3  read address: 0=RXDATA, 2=STATUS.
- O_RDATA  in  8  read data from the SPI master.

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; round-robin pointer = NUM_REQ-1, so requester 0 wins first; poll counter = 0.
- Reset mid-transfer aborts immediately. No disable write is issued and no done pulse is produced.
- Write access: I_TX_EN high for exactly one cycle with I_WADDR/I_WDATA valid, followed by one cycle with I_TX_EN low. A write therefore takes 2 cycles.
- Read access: I_RX_EN high for 1 cycle, 1 wait cycle, O_RDATA registered in the 3rd cycle, decision in the 4th cycle. A read therefore takes 4 cycles.
- I_WADDR, I_WDATA and I_RADDR hold their last value when the strobes are low.
- State IDLE:
  - If any req bit is set, grant the first set bit strictly after the pointer, wrapping around.
  - On grant: latch that requester's tx_data, set grant_id, set busy, update the pointer to the grant, and go to WR_SS.
  - req bits of non-granted requesters are ignored until the FSM returns to IDLE.
- State WR_SS: write SSMASK with 1<<grant_id.
- State WR_CTRL: write CONTROL with CTRL_VAL.
- State POLL_TX: read STATUS.
  - If bit5 and bit4 are both set: clear the poll counter and go to WR_TX.
  - Otherwise: increment the counter and repeat the read.
  - If the counter reaches POLL_TIMEOUT: set the abort flag and go to WR_OFF.
- State WR_TX: write TXDATA with the latched byte.
- State POLL_RX: same as POLL_TX but tests bit6; success goes to RD_RX.
- State RD_RX: read RXDATA and latch it into rx_data.
- State WR_OFF: write CONTROL with 8'h00. This is always executed, including on abort.
- State DONE:
  - done[grant_id]=1 for one cycle; err = abort flag; busy stays high this cycle.
  - On abort, rx_data = 8'h00.
  - Clear the abort flag and poll counter, then go to IDLE. busy drops the next cycle.
- Latency: with both polls succeeding on the first read, done is high exactly 20 cycles after the first I_TX_EN cycle (the SSMASK write). Each failed poll adds 4 cycles.
- Turnaround: back-to-back requests restart with 1 IDLE cycle between the done cycle and the next SSMASK write.
- A requester dropping req after grant does not cancel its transfer; done is still pulsed.
- A new req edge from the granted requester during its own transfer is not queued. The level is re-evaluated in IDLE.
- I_TX_EN and I_RX_EN are never high in the same cycle.

Test Plan:
- Single transfer: req=4'b0001, tx_data[7:0]=8'hA5, STATUS returns 8'h70 immediately, RXDATA=8'h3C. Expected writes in order: SSMASK 8'h01, CONTROL 8'h8B, TXDATA 8'hA5, CONTROL 8'h00. done=4'b0001 exactly 20 cycles after the first I_TX_EN; rx_data=8'h3C; err=0.
- Round robin: req=4'b1011 held continuously. Grant order is 0,1,3,0; SSMASK values written are 01,02,08,01; each done pulse lands on the matching bit.
- Slow TX ready: STATUS returns 8'h00 for 3 reads, then 8'h30, then 8'h40. done arrives 12 cycles later than in the first scenario (3 failed polls × 4 cycles); err=0.
- Timeout: POLL_TIMEOUT=3, STATUS stuck at 8'h30, so TX-ready succeeds and RX-ready never does. After 3 failed RX polls the CONTROL 8'h00 write still occurs; then done=1 with err=1 and rx_data=8'h00. The next request completes normally with err=0.
- Reset mid-operation: assert I_RESETN=0 during POLL_RX. All outputs go to 0 asynchronously, no done pulse occurs, and after release requester 0 is granted first.
- Req withdrawn: requester 2 deasserts req 2 cycles after grant. The transfer completes with done=4'b0100, and the pointer then favours requester 3.
